e_muldiv_unit: RTL

- Parametrised successor of the E-stage HI/LO unit.
- Multiply ops use a fixed-latency pipelined product; divide ops use a real iterative radix-2 divider.
- Adds accumulate ops (madd/maddu/msub/msubu) and an in-flight cancel for exception flush.
- HI/LO are committed only on completion; the pipeline stalls on out_busy.

---
 rtl/e_muldiv_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/e_muldiv_unit.sv
// E-stage HI/LO unit: pipelined multiply(-accumulate), iterative radix-2 divide, flush cancel.
// Optional MULDIV_ZERO_WHEN_BUSY_EN: out_hi/out_lo read 0 while out_busy is high.
module e_muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_num1,
    input  logic [WIDTH-1:0] in_num2,
    input  logic             in_cancel,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic             out_busy
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + MULT_LAT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [W2-1:0]    prod_q, prod_d;
    logic [1:0]       acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic             is_mul, is_div, is_sgn;
    logic [W2-1:0]    ext1, ext2, hilo, acc_res;
    logic [WIDTH-1:0] mag1, mag2, rem_dif, q_fix, r_fix;
    logic [WIDTH:0]   rem_sh;
    logic             ge;

    always_comb begin
        is_mul  = (in_op == 4'd1) || (in_op == 4'd2) || ((in_op >= 4'd7) && (in_op <= 4'd10));
        is_div  = (in_op == 4'd3) || (in_op == 4'd4);
        is_sgn  = (in_op == 4'd1) || (in_op == 4'd3) || (in_op == 4'd7) || (in_op == 4'd9);
        ext1    = is_sgn ? {{WIDTH{in_num1[WIDTH-1]}}, in_num1} : {{WIDTH{1'b0}}, in_num1};
        ext2    = is_sgn ? {{WIDTH{in_num2[WIDTH-1]}}, in_num2} : {{WIDTH{1'b0}}, in_num2};
        mag1    = (is_sgn && in_num1[WIDTH-1]) ? (~in_num1 + 1'b1) : in_num1;
        mag2    = (is_sgn && in_num2[WIDTH-1]) ? (~in_num2 + 1'b1) : in_num2;
        hilo    = {hi_q, lo_q};
        acc_res = (acc_q == 2'd1) ? (hilo + prod_q) :
                  (acc_q == 2'd2) ? (hilo - prod_q) : prod_q;
        // restoring step: remainder always < divisor, so the difference fits WIDTH bits
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        ge      = rem_sh >= {1'b0, dvs_q};
        rem_dif = rem_sh[WIDTH-1:0] - dvs_q;
        q_fix   = qneg_q ? (~quo_q + 1'b1) : quo_q;
        r_fix   = rneg_q ? (~rem_q + 1'b1) : rem_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: if (!in_cancel) begin
                if (is_mul) begin
                    state_d = S_MUL;
                    cnt_d   = CW'(1);
                    prod_d  = ext1 * ext2;
                    acc_d   = ((in_op == 4'd7) || (in_op == 4'd8))  ? 2'd1 :
                              ((in_op == 4'd9) || (in_op == 4'd10)) ? 2'd2 : 2'd0;
                end else if (is_div) begin
                    state_d = S_DIV;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = mag1;
                    dvs_d   = mag2;
                    dvd_d   = in_num1;
                    qneg_d  = is_sgn && (in_num1[WIDTH-1] ^ in_num2[WIDTH-1]);
                    rneg_d  = is_sgn && in_num1[WIDTH-1];
                    dz_d    = (in_num2 == '0);
                end else if (in_op == 4'd5) begin
                    hi_d = in_num1;
                end else if (in_op == 4'd6) begin
                    lo_d = in_num1;
                end
            end
            S_MUL: begin
                if (cnt_q == CW'(MULT_LAT)) begin
                    {hi_d, lo_d} = acc_res;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV: begin
                rem_d = ge ? rem_dif : rem_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            default: begin
                lo_d    = dz_q ? '1 : q_fix;
                hi_d    = dz_q ? dvd_q : r_fix;
                state_d = S_IDLE;
            end
        endcase
        // flush wins over a same-edge commit
        if ((state_q != S_IDLE) && in_cancel) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign out_busy = busy_q;
`ifdef MULDIV_ZERO_WHEN_BUSY_EN
    assign out_hi = busy_q ? '0 : hi_q;
    assign out_lo = busy_q ? '0 : lo_q;
`else
    assign out_hi = hi_q;
    assign out_lo = lo_q;
`endif
endmodule
